// File: rtl/mem_read_seq.sv
// -----------------------------------------------------------------------------
// mem_read_seq
//
// Read-side master for the CHIP-8 byte memory. It accepts one command at a
// time and sequences reads on a memory port whose output is registered
// (q arrives one cycle after re and holds while re is low). Results go out
// on a valid/ready stream.
//
//   opcode fetch (cmd_word=1): two reads, one beat {byte[a], byte[a+1]}
//   byte burst   (cmd_word=0): cmd_len reads, one beat {0, byte} per read
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   cmd_valid/ready     command handshake (ready only in IDLE, not in reset)
//   cmd_word            1 = opcode fetch, 0 = byte burst
//   cmd_addr, cmd_len   start address, burst byte count (0 is legal)
//   mem_re, mem_raddr   memory read request
//   mem_q               memory read data, valid the cycle after mem_re
//   out_valid/ready     result beat handshake
//   out_data, out_last  beat payload and final-beat flag
//   done                one-cycle pulse when a command completes
// -----------------------------------------------------------------------------
module mem_read_seq #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_word,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  output logic                    mem_re,
  output logic [ADDR_WIDTH-1:0]   mem_raddr,
  input  logic [DATA_WIDTH-1:0]   mem_q,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic                    done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPT,
    S_OUT,
    S_DONE
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [LEN_WIDTH-1:0]   count;        // bytes still to deliver, current one included
  logic                   word_mode;
  logic                   second_byte;  // word mode: high byte already captured

  logic accept;
  logic bytes_remain;

  assign accept       = cmd_valid & cmd_ready;
  assign bytes_remain = !word_mode && (count > LEN_WIDTH'(1));

  // Outputs decode straight from registered state, so they are glitch-free
  // and the memory sees a registered address.
  assign cmd_ready = (state == S_IDLE) && !rst;
  assign mem_re    = (state == S_ISSUE);
  assign mem_raddr = addr;
  assign out_valid = (state == S_OUT);
  assign out_last  = (state == S_OUT) && (word_mode || (count == LEN_WIDTH'(1)));
  assign done      = (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets its default before the case so no path through
  // this block leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          // An empty burst completes without touching memory.
          if (!cmd_word && (cmd_len == '0)) state_next = S_DONE;
          else                              state_next = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_CAPT;
      S_CAPT: begin
        if (word_mode && !second_byte) state_next = S_ISSUE;
        else                           state_next = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          if (bytes_remain) state_next = S_ISSUE;
          else              state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: address/count bookkeeping and the output beat register.
  // Address arithmetic wraps naturally at ADDR_WIDTH bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr        <= '0;
      count       <= '0;
      word_mode   <= 1'b0;
      second_byte <= 1'b0;
      out_data    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr        <= cmd_addr;
            count       <= cmd_len;
            word_mode   <= cmd_word;
            second_byte <= 1'b0;
          end
        end
        S_CAPT: begin
          if (word_mode) begin
            if (!second_byte) begin
              out_data    <= {mem_q, {DATA_WIDTH{1'b0}}};
              addr        <= addr + ADDR_WIDTH'(1);
              second_byte <= 1'b1;
            end else begin
              out_data[DATA_WIDTH-1:0] <= mem_q;
            end
          end else begin
            out_data <= {{DATA_WIDTH{1'b0}}, mem_q};
          end
        end
        S_OUT: begin
          if (out_ready && bytes_remain) begin
            addr  <= addr + ADDR_WIDTH'(1);
            count <= count - LEN_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_seq.sv
// -----------------------------------------------------------------------------
// tb_mem_read_seq
//
// Self-checking bench for mem_read_seq. A byte-array memory with a registered
// read port drives mem_q. A negedge monitor logs read requests, accepted
// beats and done pulses with their cycle offset from command acceptance
// (offset 1 = first cycle after the accepting edge). Expected addresses,
// beat payloads, last flags and timing are derived from the command alone.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_read_seq;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int LW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic            cmd_word = 1'b0;
  logic [AW-1:0]   cmd_addr = '0;
  logic [LW-1:0]   cmd_len = '0;
  logic            mem_re;
  logic [AW-1:0]   mem_raddr;
  logic [DW-1:0]   mem_q = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [2*DW-1:0] out_data;
  logic            out_last;
  logic            done;

  always #5 clk = ~clk;

  mem_read_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_word  (cmd_word),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .mem_re    (mem_re),
    .mem_raddr (mem_raddr),
    .mem_q     (mem_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done)
  );

  // Memory with registered output that holds while re is low.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (mem_re) mem_q <= mem[mem_raddr];

  int cyc  = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int re_addr_q[$];
  int re_rel_q[$];
  int beat_data_q[$];
  int beat_last_q[$];
  int beat_rel_q[$];
  int done_rel_q[$];

  always @(negedge clk) begin
    if (mem_re) begin
      re_addr_q.push_back(int'(mem_raddr));
      re_rel_q.push_back(cyc - base);
    end
    if (out_valid && out_ready) begin
      beat_data_q.push_back(int'(out_data));
      beat_last_q.push_back(int'(out_last));
      beat_rel_q.push_back(cyc - base);
    end
    if (done) done_rel_q.push_back(cyc - base);
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one edge, then drive random garbage with cmd_valid
  // still high; a busy sequencer must ignore it.
  task automatic issue(input bit word, input logic [AW-1:0] a, input logic [LW-1:0] len);
    re_addr_q.delete();
    re_rel_q.delete();
    beat_data_q.delete();
    beat_last_q.delete();
    beat_rel_q.delete();
    done_rel_q.delete();
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_word  = word;
    cmd_addr  = a;
    cmd_len   = len;
    tick();
    base      = cyc - 1;
    cmd_word  = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_len   = LW'($urandom);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check(tag, out_valid, 1);
  endtask

  task automatic wait_done(input bit rand_ready);
    int n = 0;
    while (done !== 1'b1 && n < 400) begin
      if (rand_ready) out_ready = 1'($urandom);
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    check("done_seen", done, 1);
    tick();
    check("cmd_ready_after_done", cmd_ready, 1);
    check("done_one_cycle", done, 0);
  endtask

  // Reference: a fetch reads a, a+1 and yields one packed beat; a burst reads
  // a..a+len-1 and yields one zero-extended beat per byte. With out_ready high
  // a read takes 2 cycles to surface and each beat adds one more.
  task automatic verify(input bit word, input logic [AW-1:0] a, input logic [LW-1:0] len,
                        input bit timing);
    int            nbytes = word ? 2 : int'(len);
    int            nbeats = word ? 1 : int'(len);
    logic [AW-1:0] ea;
    logic [AW-1:0] ea1;
    logic [2*DW-1:0] ed;
    check("re_count", re_addr_q.size(), nbytes);
    for (int i = 0; i < nbytes && i < re_addr_q.size(); i++) begin
      ea = a + AW'(i);
      check("re_addr", re_addr_q[i], ea);
      if (timing) check("re_cycle", re_rel_q[i], word ? 1 + 2*i : 1 + 3*i);
    end
    check("beat_count", beat_data_q.size(), nbeats);
    for (int i = 0; i < nbeats && i < beat_data_q.size(); i++) begin
      ea  = a + AW'(i);
      ea1 = a + AW'(1);
      ed  = word ? {mem[a], mem[ea1]} : {{DW{1'b0}}, mem[ea]};
      check("beat_data", beat_data_q[i], ed);
      check("beat_last", beat_last_q[i], (word || i == nbeats - 1) ? 1 : 0);
      if (timing) check("beat_cycle", beat_rel_q[i], word ? 5 : 3 + 3*i);
    end
    check("done_count", done_rel_q.size(), 1);
    if (timing && done_rel_q.size() > 0)
      check("done_cycle", done_rel_q[0], word ? 6 : (len == 0 ? 1 : 3*int'(len) + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0]   a;
    logic [LW-1:0]   len;
    logic [AW-1:0]   ea;
    logic [2*DW-1:0] hold_data;
    logic            hold_last;
    bit              word;
    bit              rr;

    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    mem[12'h200] = 8'hA2;
    mem[12'h201] = 8'h2A;
    mem[12'h000] = 8'hF0;
    mem[12'h001] = 8'h90;
    mem[12'h002] = 8'h90;
    mem[12'h003] = 8'h90;
    mem[12'h004] = 8'hF0;

    // Reset values, observed while rst is still high.
    rst = 1'b1;
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", cmd_ready, 1);

    // Opcode fetch at 0x200.
    issue(1'b1, 12'h200, 5'd0);
    wait_done(1'b0);
    verify(1'b1, 12'h200, 5'd0, 1'b1);
    if (beat_data_q.size() > 0) check("fetch_a22a", beat_data_q[0], 16'hA22A);

    // Sprite burst of the "0" glyph.
    issue(1'b0, 12'h000, 5'd5);
    wait_done(1'b0);
    verify(1'b0, 12'h000, 5'd5, 1'b1);

    // Backpressure on beat 2 of a 3-byte burst.
    a = AW'($urandom);
    out_ready = 1'b0;
    issue(1'b0, a, 5'd3);
    cmd_valid = 1'b0;
    wait_valid("bp_beat1_valid");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_valid("bp_beat2_valid");
    hold_data = out_data;
    hold_last = out_last;
    ea = a + AW'(1);
    check("bp_beat2_data", out_data, {{DW{1'b0}}, mem[ea]});
    check("bp_beat2_last", out_last, 0);
    repeat (3) begin
      tick();
      check("bp_valid_held", out_valid, 1);
      check("bp_data_held", out_data, hold_data);
      check("bp_last_held", out_last, hold_last);
      check("bp_no_re", mem_re, 0);
    end
    out_ready = 1'b1;
    tick();
    ea = a + AW'(2);
    check("bp_reissue", {mem_re, mem_raddr}, {1'b1, ea});
    wait_done(1'b0);
    verify(1'b0, a, 5'd3, 1'b0);

    // Address wrap: burst across the top and a fetch straddling it.
    issue(1'b0, 12'hFFE, 5'd4);
    wait_done(1'b0);
    verify(1'b0, 12'hFFE, 5'd4, 1'b1);
    issue(1'b1, 12'hFFF, 5'd0);
    wait_done(1'b0);
    verify(1'b1, 12'hFFF, 5'd0, 1'b1);

    // Empty burst.
    issue(1'b0, AW'($urandom), 5'd0);
    wait_done(1'b0);
    check("zero_no_re", re_addr_q.size(), 0);
    check("zero_no_beat", beat_data_q.size(), 0);
    if (done_rel_q.size() > 0) check("zero_done_cycle", done_rel_q[0], 1);

    // Reset while beat 2 of 5 waits in OUT.
    a = AW'($urandom);
    out_ready = 1'b0;
    issue(1'b0, a, 5'd5);
    cmd_valid = 1'b0;
    wait_valid("mr_beat1_valid");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_valid("mr_beat2_valid");
    rst = 1'b1;
    tick();
    check("mr_cmd_ready", cmd_ready, 0);
    check("mr_out_valid", out_valid, 0);
    check("mr_mem_re", mem_re, 0);
    check("mr_done", done, 0);
    check("mr_out_last", out_last, 0);
    check("mr_out_data", out_data, 0);
    rst = 1'b0;
    #1;
    check("mr_ready_back", cmd_ready, 1);
    repeat (3) tick();
    check("mr_no_done", done_rel_q.size(), 0);
    check("mr_beats", beat_data_q.size(), 1);
    out_ready = 1'b1;
    a = AW'($urandom);
    issue(1'b0, a, 5'd4);
    wait_done(1'b0);
    verify(1'b0, a, 5'd4, 1'b1);

    // Random commands; odd iterations randomise out_ready and skip timing.
    for (int k = 0; k < 12; k++) begin
      word = 1'($urandom);
      a    = AW'($urandom);
      rr   = (k % 2) == 1;
      len  = rr ? LW'($urandom_range(0, 15)) : LW'($urandom_range(0, 31));
      issue(word, a, len);
      wait_done(rr);
      verify(word, a, len, !rr);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
